pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the performance counters.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rs1_id, rs2_id  in  5 each  source register addresses of the instruction in ID.
REQ-005 use_rs1_id, use_rs2_id  in  1 each  the ID instruction actually reads rs1 / rs2.
REQ-006 wr_addr_id2exe, RegW_id2exe, load_id2exe  in  5/1/1  destination, write-enable and is-load of the instruction in EXE.
REQ-007 wr_addr_exe2lsu, RegW_exe2lsu  in  5/1  destination and write-enable of the instruction in LSU.
REQ-008 pcbranch  in  1  registered branch-taken flag from EXE; high for one cycle per taken branch or jump.
REQ-009 stall_if, stall_id  out  1 each  hold the PC and the IF/ID register.
REQ-010 bubble_exe  out  1  load a NOP into ID/EXE (clears RegW, Ld/St controls and branch_cntr).
REQ-011 flush_ifid  out  1  invalidate the IF/ID register.
REQ-012 pc_redirect  out  1  select the branch target as the next PC.
REQ-013 fwd_a, fwd_b  out  2 each  EXE operand source: 00 register file, 01 alu_result in LSU, 10 LSU write-back data.
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-015 The FSM SHALL have three states: RUN, STALL and FLUSH.
REQ-016 A load-use hazard SHALL be raised when load_id2exe=1, RegW_id2exe=1, wr_addr_id2exe!=0, and wr_addr_id2exe equals rs1_id (with use_rs1_id=1) or rs2_id (with use_rs2_id=1).
REQ-017 In RUN with a hazard and pcbranch=0, stall_if, stall_id and bubble_exe SHALL assert combinationally in that cycle, and the FSM SHALL move to STALL.
REQ-018 STALL SHALL last exactly one cycle; hazard detection is masked and the FSM returns to RUN, so the stall penalty is exactly one cycle.
REQ-019 When pcbranch=1 in any state, flush_ifid, bubble_exe and pc_redirect SHALL assert combinationally, stall_if/stall_id SHALL deassert, and the FSM SHALL move to FLUSH.
REQ-020 pcbranch SHALL take priority over a coincident load-use hazard; no stall occurs and stall_cnt does not increment.
REQ-021 FLUSH SHALL last one cycle with hazard detection masked, because ID holds an invalidated slot; the FSM then returns to RUN, or re-enters FLUSH if pcbranch=1.
REQ-022 Forwarding selects SHALL be computed from rs1_id/rs2_id and registered on each edge where ID advances into EXE (stall_id=0 and bubble_exe=0).
REQ-023 Forwarding priority SHALL be: 01 when RegW_id2exe=1 and wr_addr_id2exe matches; else 10 when RegW_exe2lsu=1 and wr_addr_exe2lsu matches; else 00.
REQ-024 Register address 0 SHALL never produce a forward or a hazard.
REQ-025 On a bubble edge, fwd_a and fwd_b SHALL register 00.
REQ-026 On a STALL exit edge, selects SHALL be recomputed against the then-current EXE/LSU fields; the load now in LSU yields 10.
REQ-027 stall_cnt SHALL increment on each RUN->STALL transition, and flush_cnt on each cycle with pcbranch=1.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 While rst_n=0, the FSM SHALL be RUN, fwd_a=fwd_b=00, both counters 0, and all combinational control outputs 0, regardless of the other inputs.
REQ-030 A reset asserted mid-STALL or mid-FLUSH SHALL abort it immediately; the first edge after release operates from RUN.

Verification
REQ-031 lw x5 in EXE (load_id2exe=1, wr_addr_id2exe=5), ID reads rs1=5 -> stall_if=stall_id=bubble_exe=1 for one cycle, then fwd_a=10, stall_cnt=1.
REQ-032 add x3 in EXE and add x4 in LSU, ID reads rs1=3, rs2=4 -> next cycle fwd_a=01, fwd_b=10; same case with both producers writing x3 -> fwd_a=01.
REQ-033 Load-use hazard and pcbranch=1 in the same cycle -> flush_ifid=pc_redirect=bubble_exe=1, stall_if=0, stall_cnt unchanged, flush_cnt+1, FSM=FLUSH.
REQ-034 Producer writes x0 (wr_addr=0, RegW=1, load=1), ID reads x0 -> no stall, fwd=00.
REQ-035 CNT_W=4: 17 load-use stalls -> stall_cnt=15 and holds.
REQ-036 rst_n pulsed low during STALL -> outputs 0 asynchronously; after release, an identical hazard stalls again for exactly one cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, EXE operand
// forwarding selects and saturating stall/flush performance counters.

// Per-operand forwarding select: EXE producer wins over LSU producer,
// and x0 never forwards.
module pipe_ctrl_fwd (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_wa_exe,
  input  logic       i_rw_exe,
  input  logic [4:0] i_wa_lsu,
  input  logic       i_rw_lsu,
  output logic [1:0] o_sel
);
  // priority compare against the two in-flight producers
  always_comb begin
    o_sel = 2'b00;
    if (i_rs != 5'd0) begin
      if (i_rw_exe && (i_wa_exe == i_rs))      o_sel = 2'b01;
      else if (i_rw_lsu && (i_wa_lsu == i_rs)) o_sel = 2'b10;
    end
  end
endmodule

// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_ctrl_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // count while enabled and not yet saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (i_inc && ~&r_cnt)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       wr_addr_id2exe,
  input  logic             RegW_id2exe,
  input  logic             load_id2exe,
  input  logic [4:0]       wr_addr_exe2lsu,
  input  logic             RegW_exe2lsu,
  input  logic             pcbranch,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_exe,
  output logic             flush_ifid,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPS = 2;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic                     w_hit1;
  logic                     w_hit2;
  logic                     w_lu_hazard;
  logic                     w_branch;
  logic                     w_stall;
  logic                     w_bubble;
  logic                     w_advance;
  logic [NUM_OPS-1:0][4:0]  w_rs;
  logic [NUM_OPS-1:0][1:0]  w_fwd_sel;
  logic [NUM_OPS-1:0][1:0]  r_fwd;

  // Load-use detection; only armed in RUN. STALL and FLUSH mask it because
  // the load has already moved on or ID holds an invalidated slot.
  assign w_hit1      = use_rs1_id && (rs1_id == wr_addr_id2exe);
  assign w_hit2      = use_rs2_id && (rs2_id == wr_addr_id2exe);
  assign w_lu_hazard = load_id2exe && RegW_id2exe && (wr_addr_id2exe != 5'd0) &&
                       (w_hit1 || w_hit2) && (r_state == S_RUN);

  // Controls are forced low while reset is held so the pipe sees no stray
  // stall/flush before the FSM is alive. Branch beats a coincident stall.
  assign w_branch  = rst_n && pcbranch;
  assign w_stall   = rst_n && w_lu_hazard && !pcbranch;
  assign w_bubble  = w_stall || w_branch;
  assign w_advance = !w_stall && !w_bubble;

  assign stall_if    = w_stall;
  assign stall_id    = w_stall;
  assign bubble_exe  = w_bubble;
  assign flush_ifid  = w_branch;
  assign pc_redirect = w_branch;

  // next-state: branch from anywhere goes to FLUSH; STALL/FLUSH last one cycle
  always_comb begin
    w_state_nxt = S_RUN;
    if (pcbranch)         w_state_nxt = S_FLUSH;
    else if (w_lu_hazard) w_state_nxt = S_STALL;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // one forwarding comparator per source operand
  assign w_rs = {rs2_id, rs1_id};

  generate
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      pipe_ctrl_fwd u_fwd (
        .i_rs     (w_rs[g]),
        .i_wa_exe (wr_addr_id2exe),
        .i_rw_exe (RegW_id2exe),
        .i_wa_lsu (wr_addr_exe2lsu),
        .i_rw_lsu (RegW_exe2lsu),
        .o_sel    (w_fwd_sel[g])
      );
    end
  endgenerate

  // Selects travel with the instruction into EXE; a bubble carries none.
  // On STALL exit the compare runs against the then-current EXE/LSU, so the
  // stalled-on load is now seen in LSU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_fwd <= '0;
    else if (w_bubble)  r_fwd <= '0;
    else if (w_advance) r_fwd <= w_fwd_sel;
  end

  assign fwd_a = r_fwd[0];
  assign fwd_b = r_fwd[1];

  // stall count on each RUN->STALL entry, flush count on each branch cycle
  pipe_ctrl_satcnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

  pipe_ctrl_satcnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_branch),
    .o_cnt (flush_cnt)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of single-cycle vectors from reset plus
// multi-cycle sequences for STALL/FLUSH timing, saturation and reset abort.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_id, rs2_id, wr_addr_id2exe, wr_addr_exe2lsu;
  logic       use_rs1_id, use_rs2_id, RegW_id2exe, load_id2exe, RegW_exe2lsu, pcbranch;

  logic        stall_if, stall_id, bubble_exe, flush_ifid, pc_redirect;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall_if, s_stall_id, s_bubble_exe, s_flush_ifid, s_pc_redirect;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .wr_addr_id2exe(wr_addr_id2exe), .RegW_id2exe(RegW_id2exe), .load_id2exe(load_id2exe),
    .wr_addr_exe2lsu(wr_addr_exe2lsu), .RegW_exe2lsu(RegW_exe2lsu), .pcbranch(pcbranch),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_exe(bubble_exe),
    .flush_ifid(flush_ifid), .pc_redirect(pc_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .wr_addr_id2exe(wr_addr_id2exe), .RegW_id2exe(RegW_id2exe), .load_id2exe(load_id2exe),
    .wr_addr_exe2lsu(wr_addr_exe2lsu), .RegW_exe2lsu(RegW_exe2lsu), .pcbranch(pcbranch),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_exe(s_bubble_exe),
    .flush_ifid(s_flush_ifid), .pc_redirect(s_pc_redirect),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    string      nm;
    logic [4:0] rs1, rs2, we, wl;
    logic       u1, u2, rwe, lde, rwl, br;
    logic       es, eb, ef;      // expected stall, bubble, flush (same cycle)
    logic [1:0] fa, fb;          // expected selects after the edge
    int         sc, fc;          // expected counters after the edge (16-bit DUT)
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(string nm, int rs1, int rs2, int u1, int u2,
                              int we, int rwe, int lde, int wl, int rwl, int br,
                              int es, int eb, int ef, int fa, int fb, int sc, int fc);
    vec_t v;
    v.nm = nm; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.u1 = u1[0]; v.u2 = u2[0];
    v.we = we[4:0]; v.rwe = rwe[0]; v.lde = lde[0]; v.wl = wl[4:0]; v.rwl = rwl[0];
    v.br = br[0]; v.es = es[0]; v.eb = eb[0]; v.ef = ef[0];
    v.fa = fa[1:0]; v.fb = fb[1:0]; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic int sat4(int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_id = v.rs1; rs2_id = v.rs2; use_rs1_id = v.u1; use_rs2_id = v.u2;
    wr_addr_id2exe = v.we; RegW_id2exe = v.rwe; load_id2exe = v.lde;
    wr_addr_exe2lsu = v.wl; RegW_exe2lsu = v.rwl; pcbranch = v.br;
    exp_q.push_back(v);
  endtask

  // called at posedge+1: drive, check controls mid-cycle, check state after edge
  task automatic step(input vec_t v);
    vec_t c;
    drive(v);
    #3;
    if (exp_q.size() == 0) begin
      chk({v.nm, ".queue"}, 0, 1);
      c = v;
    end else c = exp_q.pop_front();
    chk({c.nm, ".stall_if"},    32'(stall_if),    32'(c.es));
    chk({c.nm, ".stall_id"},    32'(stall_id),    32'(c.es));
    chk({c.nm, ".bubble_exe"},  32'(bubble_exe),  32'(c.eb));
    chk({c.nm, ".flush_ifid"},  32'(flush_ifid),  32'(c.ef));
    chk({c.nm, ".pc_redirect"}, 32'(pc_redirect), 32'(c.ef));
    @(posedge clk);
    #1;
    chk({c.nm, ".fwd_a"},       32'(fwd_a),       32'(c.fa));
    chk({c.nm, ".fwd_b"},       32'(fwd_b),       32'(c.fb));
    chk({c.nm, ".stall_cnt"},   32'(stall_cnt),   c.sc);
    chk({c.nm, ".flush_cnt"},   32'(flush_cnt),   c.fc);
    chk({c.nm, ".stall_cnt4"},  32'(s_stall_cnt), sat4(c.sc));
    chk({c.nm, ".flush_cnt4"},  32'(s_flush_cnt), sat4(c.fc));
  endtask

  // Assert reset with a hazard + branch on the inputs; everything must read 0
  // at once. Returns at posedge+1 with reset just released.
  task automatic do_reset();
    rs1_id = 5'd5; rs2_id = 5'd5; use_rs1_id = 1'b1; use_rs2_id = 1'b1;
    wr_addr_id2exe = 5'd5; RegW_id2exe = 1'b1; load_id2exe = 1'b1;
    wr_addr_exe2lsu = 5'd5; RegW_exe2lsu = 1'b1; pcbranch = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst.stall_if",    32'(stall_if),    0);
    chk("rst.bubble_exe",  32'(bubble_exe),  0);
    chk("rst.flush_ifid",  32'(flush_ifid),  0);
    chk("rst.pc_redirect", 32'(pc_redirect), 0);
    chk("rst.fwd",         32'({fwd_a, fwd_b}), 0);
    chk("rst.stall_cnt",   32'(stall_cnt),   0);
    chk("rst.flush_cnt",   32'(flush_cnt),   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  vec_t H, Hb;

  initial begin
    // hazard: lw x5 in EXE, ID reads x5/x6
    H  = mk("H",  5,6,1,1, 5,1,1, 0,0, 0,  1,1,0, 0,0, 1,0);
    tbl[0] = mk("lu_rs1",   5,6,1,1, 5,1,1, 0,0, 0,  1,1,0, 0,0, 1,0);
    tbl[1] = mk("lu_rs2",   1,9,1,1, 9,1,1, 0,0, 0,  1,1,0, 0,0, 1,0);
    tbl[2] = mk("no_use",   5,6,0,1, 5,1,1, 0,0, 0,  0,0,0, 1,0, 0,0);
    tbl[3] = mk("alu_fwd",  3,4,1,1, 3,1,0, 4,1, 0,  0,0,0, 1,2, 0,0);
    tbl[4] = mk("both_x3",  3,3,1,1, 3,1,0, 3,1, 0,  0,0,0, 1,1, 0,0);
    tbl[5] = mk("lsu_only", 7,2,1,1, 7,0,1, 7,1, 0,  0,0,0, 2,0, 0,0);
    tbl[6] = mk("br_hz",    5,6,1,1, 5,1,1, 0,0, 1,  0,1,1, 0,0, 0,1);
    tbl[7] = mk("x0",       0,0,1,1, 0,1,1, 0,1, 0,  0,0,0, 0,0, 0,0);
    tbl[8] = mk("br_only",  3,4,1,1, 3,1,0, 4,1, 1,  0,1,1, 0,0, 0,1);
    tbl[9] = mk("nomatch",  1,2,1,1, 3,1,1, 4,1, 0,  0,0,0, 0,0, 0,0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      step(tbl[i]);
    end

    // load-use: one stall, then the load sits in LSU -> fwd_a=10
    do_reset();
    step(mk("lu_a0", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,0));
    step(mk("lu_a1", 5,6,1,1, 0,0,0, 5,1, 0, 0,0,0, 2,0, 1,0));
    step(mk("lu_a2", 5,6,1,1, 0,0,0, 5,1, 0, 0,0,0, 2,0, 1,0));

    // STALL masks a still-present hazard for exactly one cycle
    do_reset();
    step(mk("msk0", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,0));
    step(mk("msk1", 5,6,1,1, 5,1,1, 0,0, 0, 0,0,0, 1,0, 1,0));
    step(mk("msk2", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 2,0));

    // branch priority, FLUSH masking, branch out of STALL, FLUSH re-entry
    do_reset();
    step(mk("fl0", 5,6,1,1, 5,1,1, 0,0, 1, 0,1,1, 0,0, 0,1));
    step(mk("fl1", 5,6,1,1, 5,1,1, 0,0, 0, 0,0,0, 1,0, 0,1));
    step(mk("fl2", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,1));
    step(mk("fl3", 5,6,1,1, 5,1,1, 0,0, 1, 0,1,1, 0,0, 1,2));
    step(mk("fl4", 1,2,0,0, 0,0,0, 0,0, 1, 0,1,1, 0,0, 1,3));
    step(mk("fl5", 5,6,1,1, 5,1,1, 0,0, 0, 0,0,0, 1,0, 1,3));
    step(mk("fl6", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 2,3));

    // counter saturation: 17 stalls, 16 flushes
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(mk("sat_st", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, i+1,0));
      step(mk("sat_mk", 5,6,1,1, 5,1,1, 0,0, 0, 0,0,0, 1,0, i+1,0));
    end
    for (int j = 0; j < 16; j++)
      step(mk("sat_fl", 1,2,0,0, 0,0,0, 0,0, 1, 0,1,1, 0,0, 17,j+1));

    // reset mid-STALL: aborts, and the same hazard stalls again for one cycle
    do_reset();
    step(mk("rs_st0", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,0));
    do_reset();
    step(mk("rs_st1", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,0));
    step(mk("rs_st2", 5,6,1,1, 0,0,0, 5,1, 0, 0,0,0, 2,0, 1,0));

    // reset mid-FLUSH: first cycle after release is RUN, hazard not masked
    do_reset();
    step(mk("rs_fl0", 1,2,0,0, 0,0,0, 0,0, 1, 0,1,1, 0,0, 0,1));
    do_reset();
    step(mk("rs_fl1", 5,6,1,1, 5,1,1, 0,0, 0, 1,1,0, 0,0, 1,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
